// File: rtl/ffs_iter.sv
// ffs_iter: iterates over the set bits of an accepted vector and emits one
// bit index per output handshake. MODE=0 emits lowest-first, MODE=1
// highest-first.
// Optional build macro FFS_ITER_EMPTY_FLUSH_EN: an accepted all-zero vector
// produces a single beat flagged with out_empty_o instead of being dropped.

// Priority encoder returning the index of the lowest (MODE=0) or highest
// (MODE=1) set bit of in_vec; returns 0 for an all-zero input.
module ffs_iter_lzc #(
  parameter int   WIDTH = 8,
  parameter logic MODE  = 1'b0,
  parameter int   IW    = 3
) (
  input  logic [WIDTH-1:0] in_vec,
  output logic [IW-1:0]    idx
);

  // Later loop iterations win, so the scan order picks the reported bit
  always_comb begin
    idx = '0;
    if (MODE == 1'b0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_vec[i]) idx = IW'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_vec[i]) idx = IW'(i);
      end
    end
  end

endmodule

module ffs_iter #(
  parameter int   WIDTH = 8,
  parameter logic MODE  = 1'b0,
  localparam int  IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [IW-1:0]    out_idx_o,
  output logic             out_last_o,
  output logic             out_empty_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_nx;
  logic [WIDTH-1:0] pending_q, pending_nx;
  logic             empty_q, empty_nx;

  logic [IW-1:0]    lzc_idx;
  logic [WIDTH-1:0] bit_mask;
  logic             single_bit;
  logic             out_hs;
  logic             in_hs;
  logic             busy;

  ffs_iter_lzc #(
    .WIDTH (WIDTH),
    .MODE  (MODE),
    .IW    (IW)
  ) u_lzc (
    .in_vec (pending_q),
    .idx    (lzc_idx)
  );

  // Output decode: beat fields are forced to zero outside BUSY so reset and
  // idle present clean values regardless of pending contents
  always_comb begin
    busy        = (state_q == BUSY);
    bit_mask    = WIDTH'(1) << lzc_idx;
    // Clearing the lowest set bit leaves zero only for a one-hot vector
    single_bit  = ((pending_q & (pending_q - WIDTH'(1))) == '0);
    out_valid_o = busy;
    out_idx_o   = (busy && !empty_q) ? lzc_idx : '0;
    out_last_o  = busy && (empty_q || single_bit);
`ifdef FFS_ITER_EMPTY_FLUSH_EN
    out_empty_o = busy && empty_q;
`else
    out_empty_o = 1'b0;
`endif
    out_hs      = out_valid_o && out_ready_i;
    // A new vector may enter while the final beat leaves: zero-bubble reload
    in_ready_o  = (!busy || (out_hs && out_last_o)) && !flush_i;
    in_hs       = in_valid_i && in_ready_o;
  end

  // Next-state logic: flush overrides everything, then consume, then load
  always_comb begin
    state_nx   = state_q;
    pending_nx = pending_q;
    empty_nx   = empty_q;
    if (flush_i) begin
      state_nx   = IDLE;
      pending_nx = '0;
      empty_nx   = 1'b0;
    end else begin
      if (out_hs) begin
        pending_nx = pending_q & ~bit_mask;
        empty_nx   = 1'b0;
        if (out_last_o) state_nx = IDLE;
      end
      if (in_hs) begin
        if (in_data_i != '0) begin
          pending_nx = in_data_i;
          empty_nx   = 1'b0;
          state_nx   = BUSY;
        end else begin
`ifdef FFS_ITER_EMPTY_FLUSH_EN
          pending_nx = '0;
          empty_nx   = 1'b1;
          state_nx   = BUSY;
`else
          // Zero vector is swallowed; the FSM stays or returns to IDLE
          pending_nx = '0;
          empty_nx   = 1'b0;
`endif
        end
      end
    end
  end

  // State and pending registers; reset discards any vector in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      empty_q   <= 1'b0;
    end else begin
      state_q   <= state_nx;
      pending_q <= pending_nx;
      empty_q   <= empty_nx;
    end
  end

endmodule

// File: tb/tb_ffs_iter.sv
// Bench for ffs_iter: two instances (LSB-first and MSB-first) share one set
// of inputs and are checked against a queue-based model of the beat stream.
module tb_ffs_iter;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       in_ready0, out_valid0, out_last0, out_empty0;
  logic [2:0] out_idx0;
  logic       in_ready1, out_valid1, out_last1, out_empty1;
  logic [2:0] out_idx1;

  ffs_iter #(.WIDTH(8), .MODE(1'b0)) dut0 (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready0),
    .in_data_i   (in_data),
    .out_valid_o (out_valid0),
    .out_ready_i (out_ready),
    .out_idx_o   (out_idx0),
    .out_last_o  (out_last0),
    .out_empty_o (out_empty0)
  );

  ffs_iter #(.WIDTH(8), .MODE(1'b1)) dut1 (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready1),
    .in_data_i   (in_data),
    .out_valid_o (out_valid1),
    .out_ready_i (out_ready),
    .out_idx_o   (out_idx1),
    .out_last_o  (out_last1),
    .out_empty_o (out_empty1)
  );

  always #5 clk = ~clk;

`ifdef FFS_ITER_EMPTY_FLUSH_EN
  localparam bit EMPTY_EN = 1'b1;
`else
  localparam bit EMPTY_EN = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Model: remaining indices of the current vector in emission order
  int q_lo[$];
  int q_hi[$];
  bit m_empty_beat;
  bit m_valid;
  bit m_ready;

  logic [6:0] exp0, exp1, got0, got1;

  task automatic model_clear();
    q_lo.delete();
    q_hi.delete();
    m_empty_beat = 1'b0;
  endtask

  // Drive this cycle's inputs and derive the expected outputs from the model
  task automatic apply(input bit fl, input bit iv, input logic [7:0] d, input bit ordy);
    bit         last;
    logic [2:0] i0, i1;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    m_valid = (q_lo.size() > 0) || m_empty_beat;
    last    = m_valid && (m_empty_beat || q_lo.size() == 1);
    i0 = (m_valid && !m_empty_beat) ? 3'(q_lo[0]) : 3'd0;
    i1 = (m_valid && !m_empty_beat) ? 3'(q_hi[0]) : 3'd0;
    m_ready = (!m_valid || (ordy && last)) && !fl;
    exp0 = {m_ready, m_valid, i0, last, m_empty_beat};
    exp1 = {m_ready, m_valid, i1, last, m_empty_beat};
  endtask

  // Clock edge: update the model with the inputs the DUT just sampled
  task automatic advance();
    @(posedge clk);
    if (rst || flush) begin
      model_clear();
    end else begin
      if (m_valid && out_ready) begin
        if (q_lo.size() > 0) begin
          void'(q_lo.pop_front());
          void'(q_hi.pop_front());
        end
        m_empty_beat = 1'b0;
      end
      if (in_valid && m_ready) begin
        model_clear();
        for (int i = 0; i < 8; i++) if (in_data[i]) q_lo.push_back(i);
        for (int i = 7; i >= 0; i--) if (in_data[i]) q_hi.push_back(i);
        if (in_data == 8'h00 && EMPTY_EN) m_empty_beat = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      apply(1'b0, 1'b0, 8'h00, 1'b1);
      #3;
      got0 = {in_ready0, out_valid0, out_idx0, out_last0, out_empty0};
      got1 = {in_ready1, out_valid1, out_idx1, out_last1, out_empty1};
      n_cmp += 2;
      if (got0 !== exp0) begin n_bad++; $display("FAIL reset[%0d] lsb: got rdy/vld/idx/last/empty=%b required %b", c, got0, exp0); end
      if (got1 !== exp1) begin n_bad++; $display("FAIL reset[%0d] msb: got rdy/vld/idx/last/empty=%b required %b", c, got1, exp1); end
      advance();
    end
    rst = 1'b0;
  endtask

  // 8'b1010_0100 streamed, then again with a 3-cycle stall after the first beat
  task automatic test_order_and_stall();
    bit ordy_tab[12] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
    bit iv_tab[12]   = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    for (int c = 0; c < 12; c++) begin
      apply(1'b0, iv_tab[c], 8'b1010_0100, ordy_tab[c]);
      #3;
      got0 = {in_ready0, out_valid0, out_idx0, out_last0, out_empty0};
      got1 = {in_ready1, out_valid1, out_idx1, out_last1, out_empty1};
      n_cmp += 2;
      if (got0 !== exp0) begin n_bad++; $display("FAIL order[%0d] lsb: got rdy/vld/idx/last/empty=%b required %b", c, got0, exp0); end
      if (got1 !== exp1) begin n_bad++; $display("FAIL order[%0d] msb: got rdy/vld/idx/last/empty=%b required %b", c, got1, exp1); end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d_tab[4]  = '{8'h01, 8'h80, 8'h00, 8'h00};
    bit         iv_tab[4] = '{1, 1, 0, 0};
    for (int c = 0; c < 4; c++) begin
      apply(1'b0, iv_tab[c], d_tab[c], 1'b1);
      #3;
      got0 = {in_ready0, out_valid0, out_idx0, out_last0, out_empty0};
      got1 = {in_ready1, out_valid1, out_idx1, out_last1, out_empty1};
      n_cmp += 2;
      if (got0 !== exp0) begin n_bad++; $display("FAIL b2b[%0d] lsb: got rdy/vld/idx/last/empty=%b required %b", c, got0, exp0); end
      if (got1 !== exp1) begin n_bad++; $display("FAIL b2b[%0d] msb: got rdy/vld/idx/last/empty=%b required %b", c, got1, exp1); end
      advance();
    end
  endtask

  // 8'hFF, two beats, then flush with a competing input that must be refused
  task automatic test_flush();
    bit fl_tab[6] = '{0, 0, 0, 1, 0, 0};
    bit iv_tab[6] = '{1, 0, 0, 1, 0, 0};
    for (int c = 0; c < 6; c++) begin
      apply(fl_tab[c], iv_tab[c], (c == 0) ? 8'hFF : 8'h55, 1'b1);
      #3;
      got0 = {in_ready0, out_valid0, out_idx0, out_last0, out_empty0};
      got1 = {in_ready1, out_valid1, out_idx1, out_last1, out_empty1};
      n_cmp += 2;
      if (got0 !== exp0) begin n_bad++; $display("FAIL flush[%0d] lsb: got rdy/vld/idx/last/empty=%b required %b", c, got0, exp0); end
      if (got1 !== exp1) begin n_bad++; $display("FAIL flush[%0d] msb: got rdy/vld/idx/last/empty=%b required %b", c, got1, exp1); end
      advance();
    end
  endtask

  task automatic test_zero_vector();
    for (int c = 0; c < 4; c++) begin
      apply(1'b0, c == 0, 8'h00, 1'b1);
      #3;
      got0 = {in_ready0, out_valid0, out_idx0, out_last0, out_empty0};
      got1 = {in_ready1, out_valid1, out_idx1, out_last1, out_empty1};
      n_cmp += 2;
      if (got0 !== exp0) begin n_bad++; $display("FAIL zero[%0d] lsb: got rdy/vld/idx/last/empty=%b required %b", c, got0, exp0); end
      if (got1 !== exp1) begin n_bad++; $display("FAIL zero[%0d] msb: got rdy/vld/idx/last/empty=%b required %b", c, got1, exp1); end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    apply(1'b0, 1'b1, 8'hF0, 1'b1);
    advance();
    apply(1'b0, 1'b0, 8'h00, 1'b1);
    advance();
    // Now BUSY with 8'hF0 partly consumed; assert reset mid-cycle
    apply(1'b0, 1'b0, 8'h00, 1'b0);
    #1 rst = 1'b1;
    model_clear();
    apply(1'b0, 1'b0, 8'h00, 1'b0);
    #1;
    got0 = {in_ready0, out_valid0, out_idx0, out_last0, out_empty0};
    got1 = {in_ready1, out_valid1, out_idx1, out_last1, out_empty1};
    n_cmp += 2;
    if (got0 !== exp0) begin n_bad++; $display("FAIL rst_mid lsb: got rdy/vld/idx/last/empty=%b required %b", got0, exp0); end
    if (got1 !== exp1) begin n_bad++; $display("FAIL rst_mid msb: got rdy/vld/idx/last/empty=%b required %b", got1, exp1); end
    advance();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      apply(1'b0, 1'b0, 8'h00, 1'b1);
      #3;
      got0 = {in_ready0, out_valid0, out_idx0, out_last0, out_empty0};
      got1 = {in_ready1, out_valid1, out_idx1, out_last1, out_empty1};
      n_cmp += 2;
      if (got0 !== exp0) begin n_bad++; $display("FAIL rst_after[%0d] lsb: got rdy/vld/idx/last/empty=%b required %b", c, got0, exp0); end
      if (got1 !== exp1) begin n_bad++; $display("FAIL rst_after[%0d] msb: got rdy/vld/idx/last/empty=%b required %b", c, got1, exp1); end
      advance();
    end
  endtask

  task automatic test_random();
    bit         fl, iv, ordy;
    logic [7:0] d;
    for (int c = 0; c < 400; c++) begin
      fl   = ($urandom_range(0, 29) == 0);
      iv   = ($urandom_range(0, 1) == 1);
      d    = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      apply(fl, iv, d, ordy);
      #3;
      got0 = {in_ready0, out_valid0, out_idx0, out_last0, out_empty0};
      got1 = {in_ready1, out_valid1, out_idx1, out_last1, out_empty1};
      n_cmp += 2;
      if (got0 !== exp0) begin n_bad++; $display("FAIL rand[%0d] lsb: got rdy/vld/idx/last/empty=%b required %b", c, got0, exp0); end
      if (got1 !== exp1) begin n_bad++; $display("FAIL rand[%0d] msb: got rdy/vld/idx/last/empty=%b required %b", c, got1, exp1); end
      advance();
    end
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    test_reset();
    test_order_and_stall();
    test_back_to_back();
    test_flush();
    test_zero_vector();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
